// File: rtl/vga_pkg.sv
// Shared timing constants, pixel field layout and helpers for the VGA display back-end.
// Default geometry is 640x480@60 Hz; modules take these as parameter defaults.
package vga_pkg;

    localparam int CLK_DIV_DEFAULT = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int COORD_W = 10;
    localparam int PIXEL_W = 12;
    localparam int CH_W    = 4;
    localparam int R_LSB   = 8;
    localparam int G_LSB   = 4;
    localparam int B_LSB   = 0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    function automatic rgb_t unpack_pixel(input logic [PIXEL_W-1:0] p);
        rgb_t c;
        c.r = p[R_LSB +: CH_W];
        c.g = p[G_LSB +: CH_W];
        c.b = p[B_LSB +: CH_W];
        return c;
    endfunction

endpackage

// File: rtl/vga_display_timing.sv
// Pixel-rate divider, horizontal/vertical counters and raw visible/sync/frame decode.
// All outputs other than the counters are combinational decodes of the current count.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int H_VIS      = H_VISIBLE,
    parameter int H_FP       = H_FRONT,
    parameter int H_SW       = H_SYNC,
    parameter int H_BP       = H_BACK,
    parameter int V_VIS      = V_VISIBLE,
    parameter int V_FP       = V_FRONT,
    parameter int V_SW       = V_SYNC,
    parameter int V_BP       = V_BACK
) (
    input  logic   clk,
    input  logic   rst,
    output coord_t h_cnt_o,
    output coord_t v_cnt_o,
    output logic   pix_tick_o,
    output logic   visible_o,
    output logic   hs_raw_o,
    output logic   vs_raw_o,
    output logic   v_blank_o,
    output logic   frame_start_o
);

    localparam int H_TOT   = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SW + V_BP;
    localparam int HS_BEG  = H_VIS + H_FP;
    localparam int HS_END  = HS_BEG + H_SW;
    localparam int VS_BEG  = V_VIS + V_FP;
    localparam int VS_END  = VS_BEG + V_SW;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    coord_t           h_cnt_q, h_cnt_d;
    coord_t           v_cnt_q, v_cnt_d;
    logic             pix_tick;
    logic             h_last;
    logic             v_last;

    assign pix_tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign h_last   = (h_cnt_q == COORD_W'(H_TOT - 1));
    assign v_last   = (v_cnt_q == COORD_W'(V_TOT - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_tick) begin
            div_cnt_d = '0;
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign h_cnt_o    = h_cnt_q;
    assign v_cnt_o    = v_cnt_q;
    assign pix_tick_o = pix_tick;
    assign visible_o  = (h_cnt_q < COORD_W'(H_VIS)) && (v_cnt_q < COORD_W'(V_VIS));
    assign v_blank_o  = (v_cnt_q >= COORD_W'(V_VIS));

    // Sync pulses are active low inside their window.
    assign hs_raw_o = !((h_cnt_q >= COORD_W'(HS_BEG)) && (h_cnt_q < COORD_W'(HS_END)));
    assign vs_raw_o = !((v_cnt_q >= COORD_W'(VS_BEG)) && (v_cnt_q < COORD_W'(VS_END)));

    // The tick that wraps both counters back to the origin.
    assign frame_start_o = pix_tick && h_last && v_last;

endmodule

// File: rtl/vga_display.sv
// VGA display back-end: drives framebuffer coordinates and registers the returned
// pixel plus sync so colour and sync leave one pixel period behind the counters.
module vga_display
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int H_VIS     = H_VISIBLE,
    parameter int H_FP      = H_FRONT,
    parameter int H_SW      = H_SYNC,
    parameter int H_BP      = H_BACK,
    parameter int V_VIS     = V_VISIBLE,
    parameter int V_FP      = V_FRONT,
    parameter int V_SW      = V_SYNC,
    parameter int V_BP      = V_BACK
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    input  logic [PIXEL_W-1:0] pixel,
    output logic [CH_W-1:0]    vga_r,
    output logic [CH_W-1:0]    vga_g,
    output logic [CH_W-1:0]    vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vblank,
    output logic               frame_start
);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   pix_tick;
    logic   visible;
    logic   hs_raw;
    logic   vs_raw;
    logic   v_blank;

    rgb_t   rgb_q, rgb_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   vblank_q, vblank_d;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SW    (H_SW),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SW    (V_SW),
        .V_BP    (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .pix_tick_o    (pix_tick),
        .visible_o     (visible),
        .hs_raw_o      (hs_raw),
        .vs_raw_o      (vs_raw),
        .v_blank_o     (v_blank),
        .frame_start_o (frame_start)
    );

    // Blanked coordinates collapse to 0 so memory addresses never leave the buffer.
    assign pixel_x = visible ? h_cnt : '0;
    assign pixel_y = visible ? v_cnt : '0;

    always_comb begin
        rgb_d    = rgb_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        vblank_d = vblank_q;
        if (pix_tick) begin
            rgb_d    = visible ? unpack_pixel(pixel) : '0;
            hs_d     = hs_raw;
            vs_d     = vs_raw;
            vblank_d = v_blank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            vblank_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            vblank_q <= vblank_d;
        end
    end

    assign vga_r  = rgb_q.r;
    assign vga_g  = rgb_q.g;
    assign vga_b  = rgb_q.b;
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign vblank = vblank_q;

endmodule

// File: tb/tb_vga_display.sv
// Directed bench: three vga_display instances (default CLK_DIV=4, CLK_DIV=3, and a
// tiny geometry for whole-frame timing) checked at hand-computed clock offsets.
module tb_vga_display;

    logic clk;
    logic rst;
    int   cyc;
    int   rel;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default 640x480, CLK_DIV=4, 2-clk memory model
    logic [9:0]  px_a, py_a;
    logic [11:0] pix_a, mem_a1;
    logic [3:0]  r_a, g_a, b_a;
    logic        hs_a, vs_a, vb_a, fs_a;

    always @(posedge clk) begin
        mem_a1 <= {px_a[3:0], py_a[3:0], 4'hC};
        pix_a  <= mem_a1;
    end

    vga_display #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .pixel_x(px_a), .pixel_y(py_a), .pixel(pix_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .vblank(vb_a), .frame_start(fs_a)
    );

    // Instance C: default geometry, CLK_DIV=3, same memory model
    logic [9:0]  px_c, py_c;
    logic [11:0] pix_c, mem_c1;
    logic [3:0]  r_c, g_c, b_c;
    logic        hs_c, vs_c, vb_c, fs_c;

    always @(posedge clk) begin
        mem_c1 <= {px_c[3:0], py_c[3:0], 4'hC};
        pix_c  <= mem_c1;
    end

    vga_display #(.CLK_DIV(3)) dut_c (
        .clk(clk), .rst(rst), .pixel_x(px_c), .pixel_y(py_c), .pixel(pix_c),
        .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .vga_hs(hs_c), .vga_vs(vs_c),
        .vblank(vb_c), .frame_start(fs_c)
    );

    // Instance B: 15x10 total (8x6 visible), CLK_DIV=4, pixel held at FFF
    logic [9:0]  px_b, py_b;
    logic [11:0] pix_b;
    logic [3:0]  r_b, g_b, b_b;
    logic        hs_b, vs_b, vb_b, fs_b;

    vga_display #(
        .CLK_DIV(4), .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SW(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst(rst), .pixel_x(px_b), .pixel_y(py_b), .pixel(pix_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .vblank(vb_b), .frame_start(fs_b)
    );

    task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, obs);
        end
    endtask

    // Advance to the negedge following the n-th posedge since reset release.
    task automatic goto(input int n);
        while ((cyc - rel) < n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rel     = 0;
        pix_b   = 12'hFFF;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        tb_check("por_hs", {31'd0, hs_a}, 32'd1);
        rst = 1'b0;
        rel = cyc;

        // First tick after release lands on the 4th clock
        goto(3);   tb_check("a_px_before_tick", px_a, 32'd0);
        goto(4);   tb_check("a_px_first_tick", px_a, 32'd1);
        goto(100); tb_check("a_px_mid", px_a, 32'd25);
                   tb_check("a_rgb_mid", {r_a, g_a, b_a}, 32'h80C);

        // Asynchronous reset mid-line, checked before any further clock edge
        rst = 1'b1;
        #1;
        tb_check("rst_rgb", {r_a, g_a, b_a}, 32'h000);
        tb_check("rst_hs", {31'd0, hs_a}, 32'd1);
        tb_check("rst_vs", {31'd0, vs_a}, 32'd1);
        tb_check("rst_vblank", {31'd0, vb_a}, 32'd0);
        tb_check("rst_fs", {31'd0, fs_a}, 32'd0);
        tb_check("rst_px", px_a, 32'd0);
        tb_check("rst_py", py_a, 32'd0);
        @(negedge clk);
        tb_check("rst_hold_rgb", {r_a, g_a, b_a}, 32'h000);
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        tb_check("rel_px", px_a, 32'd0);

        // B: blanking with pixel held at FFF, frame/vsync/vblank timing
        goto(31);   tb_check("b_px_last_col", px_b, 32'd7);
        goto(32);   tb_check("b_px_hblank", px_b, 32'd0);
        goto(35);   tb_check("b_rgb_last_col", {r_b, g_b, b_b}, 32'hFFF);
        goto(36);   tb_check("b_rgb_hblank", {r_b, g_b, b_b}, 32'h000);
        goto(301);  tb_check("b_py_row5", py_b, 32'd5);
        goto(306);  tb_check("b_rgb_row5", {r_b, g_b, b_b}, 32'hFFF);
        goto(362);  tb_check("b_py_vblank", py_b, 32'd0);
                    tb_check("b_px_vblank", px_b, 32'd0);
        goto(363);  tb_check("b_vblank_pre", {31'd0, vb_b}, 32'd0);
        goto(364);  tb_check("b_vblank_rise", {31'd0, vb_b}, 32'd1);
        goto(366);  tb_check("b_rgb_vblank", {r_b, g_b, b_b}, 32'h000);
        goto(423);  tb_check("b_vs_pre", {31'd0, vs_b}, 32'd1);
        goto(424);  tb_check("b_vs_fall", {31'd0, vs_b}, 32'd0);
        goto(543);  tb_check("b_vs_low_end", {31'd0, vs_b}, 32'd0);
        goto(544);  tb_check("b_vs_rise", {31'd0, vs_b}, 32'd1);
        goto(598);  tb_check("b_fs_pre", {31'd0, fs_b}, 32'd0);
        goto(599);  tb_check("b_fs_pulse", {31'd0, fs_b}, 32'd1);
        goto(600);  tb_check("b_fs_post", {31'd0, fs_b}, 32'd0);
        goto(603);  tb_check("b_vblank_end", {31'd0, vb_b}, 32'd1);
        goto(604);  tb_check("b_vblank_fall", {31'd0, vb_b}, 32'd0);
        goto(1199); tb_check("b_fs_pulse2", {31'd0, fs_b}, 32'd1);

        // C (CLK_DIV=3): 2400-clk line, hsync 96*3 clk, first column 0
        goto(1970); tb_check("c_hs_pre", {31'd0, hs_c}, 32'd1);
        goto(1971); tb_check("c_hs_fall", {31'd0, hs_c}, 32'd0);
        goto(2258); tb_check("c_hs_low_end", {31'd0, hs_c}, 32'd0);
        goto(2259); tb_check("c_hs_rise", {31'd0, hs_c}, 32'd1);
        goto(2402); tb_check("c_rgb_line_pre", {r_c, g_c, b_c}, 32'h000);
        goto(2403); tb_check("c_rgb_col0", {r_c, g_c, b_c}, 32'h01C);

        // A (CLK_DIV=4): last visible column, hsync window, first column
        goto(2556); tb_check("a_px_639", px_a, 32'd639);
        goto(2560); tb_check("a_px_hblank", px_a, 32'd0);
        goto(2627); tb_check("a_hs_pre", {31'd0, hs_a}, 32'd1);
        goto(2628); tb_check("a_hs_fall", {31'd0, hs_a}, 32'd0);
        goto(3011); tb_check("a_hs_low_end", {31'd0, hs_a}, 32'd0);
        goto(3012); tb_check("a_hs_rise", {31'd0, hs_a}, 32'd1);
        goto(3203); tb_check("a_rgb_line_pre", {r_a, g_a, b_a}, 32'h000);
        goto(3204); tb_check("a_rgb_col0", {r_a, g_a, b_a}, 32'h01C);
        goto(3208); tb_check("a_rgb_col1", {r_a, g_a, b_a}, 32'h11C);

        goto(4370); tb_check("c_hs_pre2", {31'd0, hs_c}, 32'd1);
        goto(4371); tb_check("c_hs_fall2", {31'd0, hs_c}, 32'd0);
        goto(5827); tb_check("a_hs_pre2", {31'd0, hs_a}, 32'd1);
        goto(5828); tb_check("a_hs_fall2", {31'd0, hs_a}, 32'd0);

        // Colour alignment at (5,3)
        goto(7217); tb_check("c_rgb_4_3", {r_c, g_c, b_c}, 32'h43C);
        goto(7218); tb_check("c_rgb_5_3", {r_c, g_c, b_c}, 32'h53C);
        goto(9620); tb_check("a_px_5", px_a, 32'd5);
                    tb_check("a_py_3", py_a, 32'd3);
        goto(9623); tb_check("a_rgb_4_3", {r_a, g_a, b_a}, 32'h43C);
        goto(9624); tb_check("a_rgb_5_3", {r_a, g_a, b_a}, 32'h53C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
